ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
- Round-robin AHB-Lite bus arbiter for the SoC interconnect; shares the slave fabric (instruction SRAM, data SRAM, UART, SPI, GPIO) between the core instruction port, the core data port and any future masters.
- Samples per-master request, lock, transfer type and burst type, then drives one-hot grants to the masters.
- Drives the address-phase and data-phase owner indices to the bus multiplexers.
- Never hands over the bus in the middle of a fixed-length burst or a locked sequence.

Parameters:
- MASTERS, 2, number of masters; must be 2 or more.
- MW, $clog2(MASTERS), width of the master index.
- DEFAULT_MASTER, 0, master that is parked on the bus when no master is requesting.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- hbusreq_i, input, MASTERS, per-master bus request.
- hlock_i, input, MASTERS, per-master locked-transfer request.
- htrans_i, input, 2*MASTERS, per-master HTRANS; bits [2i+1:2i] belong to master i.
- hburst_i, input, 3*MASTERS, per-master HBURST; bits [3i+2:3i] belong to master i.
- hready_i, input, 1, bus HREADY.
- hgrant_o, output, MASTERS, one-hot grant.
- hmaster_o, output, MW, address-phase owner index.
- hmaster_data_o, output, MW, data-phase owner index.
- hmastlock_o, output, 1, current address phase is locked.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hgrant_o = one-hot(DEFAULT_MASTER).
  - hmaster_o = DEFAULT_MASTER; hmaster_data_o = DEFAULT_MASTER.
  - hmastlock_o = 0; beat counter = 0; rr_ptr = DEFAULT_MASTER.
- Owner signals: own_trans = htrans_i slice at hmaster_o; own_burst = hburst_i slice at hmaster_o.
- Burst length from own_burst:
  - SINGLE = 1.
  - INCR = unbounded.
  - WRAP4/INCR4 = 4.
  - WRAP8/INCR8 = 8.
  - WRAP16/INCR16 = 16.
- Beat counter, updated only on edges where hready_i=1:
  - Accepted NONSEQ loads len-1 (0 for SINGLE or INCR).
  - Accepted SEQ decrements, saturating at 0.
  - IDLE and BUSY hold the count.
- last_beat: (NONSEQ and len==1) or (SEQ and cnt==1) or (own_trans==IDLE).
- rearb_ok: hready_i=1, owner lock cleared, and at least one of:
  - last_beat;
  - hbusreq_i[owner]=0 with own_trans in {IDLE, NONSEQ-SINGLE};
  - INCR burst with own_trans==IDLE.
  - BUSY or a mid-burst SEQ blocks rearbitration.
- Winner: first requesting master scanning rr_ptr+1, rr_ptr+2, ... modulo MASTERS.
  - If no master is requesting, the winner is DEFAULT_MASTER.
  - The current owner is eligible only after all others in the scan order (fairness).
- On an edge with rearb_ok:
  - hgrant_o <= one-hot(winner).
  - If the winner is a requester, rr_ptr <= winner.
- On an edge with hready_i=1:
  - hmaster_o <= index(hgrant_o).
  - hmaster_data_o <= hmaster_o.
  - hmastlock_o <= hlock_i[index(hgrant_o)].
- On an edge with hready_i=0: hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o and the counter all hold.
- Latency: a request in cycle N with the bus free gives grant visible at N+1, address ownership at N+2, data ownership at N+3 (all with hready_i=1).
- Lock:
  - While hlock_i[owner]=1 or hmastlock_o=1, rearbitration is suppressed.
  - Lock release takes effect at the first rearb_ok edge after hlock_i drops.
- Simultaneous events:
  - A request arriving in the same cycle as the owner's last beat takes part in that arbitration.
  - A request dropping in the same cycle is ignored.
- Reset mid-burst: the asynchronous reset clears all state immediately; no burst context survives.
- hgrant_o is always exactly one-hot; invalid HBURST codes are treated as SINGLE.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles, MASTERS=2 -> hgrant_o=2'b01, hmaster_o=0, hmaster_data_o=0, hmastlock_o=0.
2. Single-master handover:
   - Stimulus: master1 asserts hbusreq_i at cycle 10, master0 idle, hready_i=1.
   - Response: hgrant_o=2'b10 at cycle 11, hmaster_o=1 at cycle 12, hmaster_data_o=1 at cycle 13.
3. Round-robin fairness:
   - Stimulus: both masters request continuously with back-to-back NONSEQ SINGLE transfers.
   - Response: hmaster_o alternates 0,1,0,1 for 8 transfers.
4. Burst protection:
   - Stimulus: master0 issues INCR4 (NONSEQ, SEQ, SEQ, SEQ) while master1 is requesting.
   - Response: hgrant_o stays 2'b01 until the edge after the third SEQ; hmaster_o=1 on the following hready edge.
5. Wait states:
   - Stimulus: as in scenario 4, but hready_i=0 for 3 cycles during beat 2.
   - Response: counter, grant and hmaster_o freeze; handover is delayed exactly 3 cycles.
6. Lock and reset:
   - Stimulus: master0 holds hlock_i=1 across 10 SINGLE transfers with master1 requesting.
   - Response: no grant change and hmastlock_o=1; once hlock_i drops, grant moves to master1.
   - Stimulus: assert rst_n=0 mid-burst.
   - Response: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Round-robin AHB-Lite bus arbiter. Grants are one-hot and registered; the
// address-phase and data-phase owner indices follow the grant down the AHB
// pipeline. The bus never changes hands inside a fixed-length burst or while
// the owner holds a locked sequence.
module ahb_master_arbiter #(
  parameter int MASTERS        = 2,
  parameter int MW             = $clog2(MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MASTERS-1:0]     hbusreq_i,
  input  logic [MASTERS-1:0]     hlock_i,
  input  logic [2*MASTERS-1:0]   htrans_i,
  input  logic [3*MASTERS-1:0]   hburst_i,
  input  logic                   hready_i,
  output logic [MASTERS-1:0]     hgrant_o,
  output logic [MW-1:0]          hmaster_o,
  output logic [MW-1:0]          hmaster_data_o,
  output logic                   hmastlock_o
);

  localparam logic [1:0]    TRANS_IDLE   = 2'b00;
  localparam logic [1:0]    TRANS_NONSEQ = 2'b10;
  localparam logic [1:0]    TRANS_SEQ    = 2'b11;
  localparam logic [2:0]    BURST_INCR   = 3'b001;
  localparam logic [MW-1:0] DEF_IDX      = MW'(DEFAULT_MASTER);

  // Number of beats in a burst; 0 encodes an unbounded INCR burst.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    logic [4:0] len;
    case (burst)
      3'b000:         len = 5'd1;
      3'b001:         len = 5'd0;
      3'b010, 3'b011: len = 5'd4;
      3'b100, 3'b101: len = 5'd8;
      3'b110, 3'b111: len = 5'd16;
      default:        len = 5'd1;
    endcase
    return len;
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    logic [MASTERS-1:0] v;
    v = {{(MASTERS-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // Index of the set bit of a one-hot grant vector.
  function automatic logic [MW-1:0] grant_index(input logic [MASTERS-1:0] g);
    logic [MW-1:0] idx;
    idx = {MW{1'b0}};
    for (int i = 0; i < MASTERS; i++) begin
      idx = g[i] ? MW'(i) : idx;
    end
    return idx;
  endfunction

  // Round-robin scan starting after ptr; ptr itself is checked last.
  // Returns {found, index}; index is the default master when nobody requests.
  function automatic logic [MW:0] rr_pick(input logic [MASTERS-1:0] req,
                                          input logic [MW-1:0]      ptr);
    logic [MW:0] pick;
    int          j;
    pick = {1'b0, DEF_IDX};
    // Walk the order backwards so the earliest position in the scan wins.
    for (int k = MASTERS; k >= 1; k--) begin
      j    = (int'(ptr) + k) % MASTERS;
      pick = req[j] ? {1'b1, MW'(j)} : pick;
    end
    return pick;
  endfunction

  logic [MASTERS-1:0] r_grant;
  logic [MW-1:0]      r_master;
  logic [MW-1:0]      r_master_data;
  logic [MW-1:0]      r_rr_ptr;
  logic               r_mastlock;
  logic [3:0]         r_cnt;

  logic [1:0]         w_own_trans;
  logic [2:0]         w_own_burst;
  logic               w_own_req;
  logic               w_own_lock;
  logic [4:0]         w_len;
  logic               w_idle;
  logic               w_nonseq;
  logic               w_seq;
  logic               w_single_len;
  logic               w_last_beat;
  logic               w_rearb_ok;
  logic [3:0]         w_cnt_nxt;
  logic [MW:0]        w_pick;
  logic [MASTERS-1:0] w_grant_nxt;
  logic [MW-1:0]      w_rr_nxt;
  logic               w_grant_lock;

  // Select the transfer controls of the current address-phase owner.
  always_comb begin
    w_own_trans = TRANS_IDLE;
    w_own_burst = 3'b000;
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      w_own_trans = (r_master == MW'(i)) ? htrans_i[2*i +: 2] : w_own_trans;
      w_own_burst = (r_master == MW'(i)) ? hburst_i[3*i +: 3] : w_own_burst;
      w_own_req   = (r_master == MW'(i)) ? hbusreq_i[i]       : w_own_req;
      w_own_lock  = (r_master == MW'(i)) ? hlock_i[i]         : w_own_lock;
    end
  end

  // Track burst beats and decide whether the bus may change hands this edge.
  always_comb begin
    w_len        = burst_len(w_own_burst);
    w_idle       = (w_own_trans == TRANS_IDLE);
    w_nonseq     = (w_own_trans == TRANS_NONSEQ);
    w_seq        = (w_own_trans == TRANS_SEQ);
    w_single_len = (w_len == 5'd1);
    case (w_own_trans)
      TRANS_NONSEQ: w_cnt_nxt = (w_len > 5'd1) ? 4'(w_len - 5'd1) : 4'd0;
      TRANS_SEQ:    w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : (r_cnt - 4'd1);
      default:      w_cnt_nxt = r_cnt;
    endcase
    w_last_beat = (w_nonseq && w_single_len) ||
                  (w_seq && (r_cnt == 4'd1)) ||
                  w_idle;
    // BUSY and mid-burst SEQ fall through every clause and hold the bus.
    w_rearb_ok  = hready_i && !w_own_lock && !r_mastlock &&
                  (w_last_beat ||
                   (!w_own_req && (w_idle || (w_nonseq && w_single_len))) ||
                   ((w_own_burst == BURST_INCR) && w_idle));
  end

  // Choose the next grant holder and round-robin pointer.
  always_comb begin
    w_pick       = rr_pick(hbusreq_i, r_rr_ptr);
    w_grant_lock = |(hlock_i & r_grant);
    if (w_rearb_ok) begin
      w_grant_nxt = onehot(w_pick[MW-1:0]);
      w_rr_nxt    = w_pick[MW] ? w_pick[MW-1:0] : r_rr_ptr;
    end else begin
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr_ptr;
    end
  end

  // Ownership pipeline: grant -> address owner -> data owner; wait states freeze it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= onehot(DEF_IDX);
      r_master      <= DEF_IDX;
      r_master_data <= DEF_IDX;
      r_mastlock    <= 1'b0;
      r_cnt         <= 4'd0;
      r_rr_ptr      <= DEF_IDX;
    end else if (hready_i) begin
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_master      <= grant_index(r_grant);
      r_master_data <= r_master;
      r_mastlock    <= w_grant_lock;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign hgrant_o       = r_grant;
  assign hmaster_o      = r_master;
  assign hmaster_data_o = r_master_data;
  assign hmastlock_o    = r_mastlock;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter
// Directed scenarios for the two-master arbiter. The stimulus thread queues
// hand-computed expected outputs stamped with the cycle they must appear in;
// a monitor on the falling edge pops and compares them.
module tb_ahb_master_arbiter;

  localparam int MASTERS = 2;
  localparam int MW      = 1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [MASTERS-1:0]   hbusreq;
  logic [MASTERS-1:0]   hlock;
  logic [2*MASTERS-1:0] htrans;
  logic [3*MASTERS-1:0] hburst;
  logic                 hready;
  logic [MASTERS-1:0]   hgrant;
  logic [MW-1:0]        hmaster;
  logic [MW-1:0]        hmaster_data;
  logic                 hmastlock;

  ahb_master_arbiter #(
    .MASTERS(MASTERS),
    .MW(MW),
    .DEFAULT_MASTER(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hbusreq_i(hbusreq),
    .hlock_i(hlock),
    .htrans_i(htrans),
    .hburst_i(hburst),
    .hready_i(hready),
    .hgrant_o(hgrant),
    .hmaster_o(hmaster),
    .hmaster_data_o(hmaster_data),
    .hmastlock_o(hmastlock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic       m;
    logic       d;
    logic       l;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Cycle number: cycle N is the interval following the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d was not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (hgrant !== e.g || hmaster !== e.m || hmaster_data !== e.d || hmastlock !== e.l) begin
        errors++;
        $display("FAIL %s cycle %0d: got grant=%b master=%0d data=%0d lock=%0d, expected grant=%b master=%0d data=%0d lock=%0d",
                 e.name, cyc, hgrant, hmaster, hmaster_data, hmastlock, e.g, e.m, e.d, e.l);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [1:0] g, input logic m,
                           input logic d, input logic l, input string name);
    exp_t e;
    e.cyc  = c;
    e.g    = g;
    e.m    = m;
    e.d    = d;
    e.l    = l;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] t0, input logic [1:0] t1,
                       input logic [2:0] b0, input logic [2:0] b1);
    hbusreq = req;
    hlock   = lock;
    htrans  = {t1, t0};
    hburst  = {b1, b0};
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         b;
    logic [9:0] rr_g;
    logic [9:0] rr_m;
    logic [9:0] rr_d;

    // Round-robin tables, bit k-1 is the value in cycle C+k.
    rr_g = 10'b1010101010;   // grant index
    rr_m = 10'b0101010100;   // address owner
    rr_d = 10'b1010101000;   // data owner

    // Reset held for five cycles.
    rst_n  = 1'b0;
    hready = 1'b1;
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    expect_at(2, 2'b01, 1'b0, 1'b0, 1'b0, "reset_c2");
    expect_at(4, 2'b01, 1'b0, 1'b0, 1'b0, "reset_c4");
    repeat (5) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single-master handover, then parking back on the default master.
    b = cyc;
    expect_at(b + 1, 2'b10, 1'b0, 1'b0, 1'b0, "handover_grant");
    expect_at(b + 2, 2'b10, 1'b1, 1'b0, 1'b0, "handover_addr");
    expect_at(b + 3, 2'b10, 1'b1, 1'b1, 1'b0, "handover_data");
    expect_at(b + 4, 2'b01, 1'b1, 1'b1, 1'b0, "park_grant");
    expect_at(b + 5, 2'b01, 1'b0, 1'b1, 1'b0, "park_addr");
    drive(2'b10, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (3) step();
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (5) step();

    // Round-robin fairness with back-to-back NONSEQ SINGLE transfers.
    b = cyc;
    for (int k = 1; k <= 10; k++) begin
      expect_at(b + k, rr_g[k-1] ? 2'b10 : 2'b01, rr_m[k-1], rr_d[k-1], 1'b0, "rr_fair");
    end
    expect_at(b + 11, 2'b01, 1'b1, 1'b0, 1'b0, "rr_release");
    drive(2'b11, 2'b00, NONSEQ, NONSEQ, SINGLE, SINGLE);
    repeat (10) step();
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (5) step();

    // INCR4 from master0 while master1 requests.
    b = cyc;
    for (int k = 1; k <= 3; k++) begin
      expect_at(b + k, 2'b01, 1'b0, 1'b0, 1'b0, "burst_hold");
    end
    expect_at(b + 4, 2'b10, 1'b0, 1'b0, 1'b0, "burst_handover_grant");
    expect_at(b + 5, 2'b10, 1'b1, 1'b0, 1'b0, "burst_handover_addr");
    expect_at(b + 6, 2'b01, 1'b1, 1'b1, 1'b0, "burst_release");
    drive(2'b10, 2'b00, NONSEQ, IDLE, INCR4, SINGLE);
    step();
    drive(2'b10, 2'b00, SEQ, IDLE, INCR4, SINGLE);
    repeat (3) step();
    drive(2'b10, 2'b00, IDLE, IDLE, INCR4, SINGLE);
    step();
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (5) step();

    // Same burst with three wait states during beat 2.
    b = cyc;
    for (int k = 1; k <= 6; k++) begin
      expect_at(b + k, 2'b01, 1'b0, 1'b0, 1'b0, "wait_hold");
    end
    expect_at(b + 7, 2'b10, 1'b0, 1'b0, 1'b0, "wait_handover_grant");
    expect_at(b + 8, 2'b10, 1'b1, 1'b0, 1'b0, "wait_handover_addr");
    drive(2'b10, 2'b00, NONSEQ, IDLE, INCR4, SINGLE);
    step();
    drive(2'b10, 2'b00, SEQ, IDLE, INCR4, SINGLE);
    hready = 1'b0;
    repeat (3) step();
    hready = 1'b1;
    repeat (3) step();
    drive(2'b10, 2'b00, IDLE, IDLE, INCR4, SINGLE);
    step();
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (5) step();

    // Locked sequence of ten SINGLE transfers, then lock release.
    b = cyc;
    for (int k = 1; k <= 10; k++) begin
      expect_at(b + k, 2'b01, 1'b0, 1'b0, 1'b1, "lock_hold");
    end
    expect_at(b + 11, 2'b01, 1'b0, 1'b0, 1'b0, "lock_drop");
    expect_at(b + 12, 2'b10, 1'b0, 1'b0, 1'b0, "lock_handover");
    expect_at(b + 13, 2'b10, 1'b1, 1'b0, 1'b0, "lock_addr");
    expect_at(b + 14, 2'b01, 1'b0, 1'b0, 1'b0, "async_reset");
    drive(2'b11, 2'b01, NONSEQ, IDLE, SINGLE, SINGLE);
    repeat (10) step();
    drive(2'b10, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (3) step();
    // Master1 starts an INCR4 burst, reset hits in the middle of it.
    drive(2'b10, 2'b00, IDLE, NONSEQ, SINGLE, INCR4);
    step();
    drive(2'b10, 2'b00, IDLE, SEQ, SINGLE, INCR4);
    #1;
    rst_n = 1'b0;
    repeat (2) step();

    // Leave reset with master1 requesting: no burst context may remain.
    b = cyc;
    expect_at(b, 2'b01, 1'b0, 1'b0, 1'b0, "reset_hold");
    expect_at(b + 1, 2'b10, 1'b0, 1'b0, 1'b0, "post_reset_grant");
    expect_at(b + 2, 2'b10, 1'b1, 1'b0, 1'b0, "post_reset_addr");
    drive(2'b10, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    rst_n = 1'b1;
    repeat (3) step();
    drive(2'b00, 2'b00, IDLE, IDLE, SINGLE, SINGLE);
    repeat (3) step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
